// File: rtl/data_bus.sv
// rtl/data_bus.sv - core data bus: word RAM, hex display, debounced switches, timer/compare
module data_bus #(
  parameter int RAM_WORDS = 64,
  parameter int DEBOUNCE  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [4:0]  SW,
  output logic [6:0]  gled,
  output logic [6:0]  gled2,
  output logic [6:0]  gled3,
  output logic [6:0]  gled4
);

  localparam int AW = $clog2(RAM_WORDS);
  // Count only has to reach DEBOUNCE-1; the load happens on that cycle.
  localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);

  // Word addresses (addr[15:2]) of the peripheral registers.
  localparam logic [13:0] WA_DISP  = 14'h3FC0;
  localparam logic [13:0] WA_SWREG = 14'h3FC1;
  localparam logic [13:0] WA_TIMER = 14'h3FC2;
  localparam logic [13:0] WA_CMP   = 14'h3FC3;
  localparam logic [13:0] WA_STAT  = 14'h3FC4;

  logic [31:0]   r_ram [RAM_WORDS];
  logic [15:0]   r_disp;
  logic [4:0]    r_sw_s1;
  logic [4:0]    r_sw_s2;
  logic [4:0]    r_sw_cand;
  logic [CW-1:0] r_db_cnt;
  logic [4:0]    r_swreg;
  logic [31:0]   r_timer;
  logic [31:0]   r_cmp;
  logic          r_match;

  logic [13:0]   w_word;
  logic          w_page0;
  logic          w_hit_ram;
  logic          w_hit_disp;
  logic          w_hit_swreg;
  logic          w_hit_timer;
  logic          w_hit_cmp;
  logic          w_hit_stat;
  logic [AW-1:0] w_ram_idx;
  logic [15:0]   w_disp_shown;
  logic          w_unused_addr;

  assign w_word      = addr[15:2];
  assign w_page0     = (addr[31:16] == 16'h0000);
  assign w_hit_ram   = w_page0 && (w_word < 14'(RAM_WORDS));
  assign w_hit_disp  = w_page0 && (w_word == WA_DISP);
  assign w_hit_swreg = w_page0 && (w_word == WA_SWREG);
  assign w_hit_timer = w_page0 && (w_word == WA_TIMER);
  assign w_hit_cmp   = w_page0 && (w_word == WA_CMP);
  assign w_hit_stat  = w_page0 && (w_word == WA_STAT);
  assign w_ram_idx   = addr[AW+1:2];
  assign w_unused_addr = ^addr[1:0];

  // Active-low segments, bit0=a .. bit6=g.
  function automatic logic [6:0] seg7(input logic [3:0] h);
    case (h)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // Blank to zeros while reset is held, even before the first reset edge.
  assign w_disp_shown = reset ? r_disp : 16'h0000;
  assign gled  = seg7(w_disp_shown[3:0]);
  assign gled2 = seg7(w_disp_shown[7:4]);
  assign gled3 = seg7(w_disp_shown[11:8]);
  assign gled4 = seg7(w_disp_shown[15:12]);

  // Combinational load mux; anything unmapped reads as zero.
  always_comb begin
    readdata = 32'h0;
    if (w_hit_ram)        readdata = r_ram[w_ram_idx];
    else if (w_hit_disp)  readdata = {16'h0, r_disp};
    else if (w_hit_swreg) readdata = {27'h0, r_sw_s2 == r_sw_s2 ? r_swreg : 5'h0};
    else if (w_hit_timer) readdata = r_timer;
    else if (w_hit_cmp)   readdata = r_cmp;
    else if (w_hit_stat)  readdata = {31'h0, r_match};
  end

  // RAM store; contents survive reset and stores still land while reset is held.
  always_ff @(posedge clk) begin
    if (memwrite && w_hit_ram) r_ram[w_ram_idx] <= writedata;
  end

  // Display and compare registers written from the bus.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_disp <= 16'h0000;
      r_cmp  <= 32'hFFFF_FFFF;
    end else if (memwrite) begin
      if (w_hit_disp) r_disp <= writedata[15:0];
      if (w_hit_cmp)  r_cmp  <= writedata;
    end
  end

  // Free-running timer with bus load, and sticky MATCH where a set beats a clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_timer <= 32'h0;
      r_match <= 1'b0;
    end else begin
      if (memwrite && w_hit_timer) r_timer <= writedata;
      else                         r_timer <= r_timer + 32'd1;
      if (r_timer == r_cmp)                            r_match <= 1'b1;
      else if (memwrite && w_hit_stat && writedata[0]) r_match <= 1'b0;
    end
  end

  // Switch synchronizer and debouncer: candidate must hold DEBOUNCE cycles to replace SWREG.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sw_s1   <= 5'h0;
      r_sw_s2   <= 5'h0;
      r_sw_cand <= 5'h0;
      r_db_cnt  <= '0;
      r_swreg   <= 5'h0;
    end else begin
      r_sw_s1 <= SW;
      r_sw_s2 <= r_sw_s1;
      if (r_sw_s2 == r_swreg) begin
        r_sw_cand <= r_sw_s2;
        r_db_cnt  <= '0;
      end else if (r_sw_s2 != r_sw_cand) begin
        r_sw_cand <= r_sw_s2;
        if (DEBOUNCE <= 1) begin
          r_swreg  <= r_sw_s2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= CW'(1);
        end
      end else if (r_db_cnt == CW'(DEBOUNCE - 1)) begin
        r_swreg  <= r_sw_s2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_bus.sv
// tb/tb_data_bus.sv - scoreboard bench for data_bus
module tb_data_bus;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [4:0]  SW;
  logic [6:0]  gled, gled2, gled3, gled4;

  logic [31:0] exp_q [$];
  logic [31:0] e;
  int          n_vec;
  int          n_err;
  logic [6:0]  seg_tab [16];

  data_bus #(.RAM_WORDS(64), .DEBOUNCE(4)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr),
    .writedata(writedata), .readdata(readdata), .SW(SW),
    .gled(gled), .gled2(gled2), .gled3(gled3), .gled4(gled4)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  function automatic logic [31:0] digits();
    return {4'h0, gled4, gled3, gled2, gled};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    writedata = d;
    memwrite = 1'b1;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] al [5];
    logic [31:0] ex [5];
    al = '{32'hFF00, 32'hFF04, 32'hFF08, 32'hFF0C, 32'hFF10};
    ex = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};
    reset = 1'b0; memwrite = 1'b0; addr = 32'h0; writedata = 32'h0; SW = 5'h0;
    #1;
    exp_q.push_back({4'h0, {4{7'b1000000}}});
    e = exp_q.pop_front(); n_vec++;
    if (digits() !== e) begin n_err++; $display("FAIL reset_gled_pre got %h want %h", digits(), e); end
    tick(2);
    for (int i = 0; i < 5; i++) exp_q.push_back(ex[i]);
    for (int i = 0; i < 5; i++) begin
      addr = al[i]; #1;
      e = exp_q.pop_front(); n_vec++;
      if (readdata !== e) begin n_err++; $display("FAIL reset_reg[%0d] got %h want %h", i, readdata, e); end
    end
    reset = 1'b1;
    addr = 32'hFF08;
    exp_q.push_back(32'h1);
    tick(1);
    e = exp_q.pop_front(); n_vec++;
    if (readdata !== e) begin n_err++; $display("FAIL first_timer got %h want %h", readdata, e); end
  endtask

  task automatic test_ram();
    logic [31:0] al [2];
    al = '{32'h0C, 32'h0F};
    store(32'h0C, 32'hDEAD_BEEF);
    for (int i = 0; i < 2; i++) exp_q.push_back(32'hDEAD_BEEF);
    for (int i = 0; i < 2; i++) begin
      addr = al[i]; #1;
      e = exp_q.pop_front(); n_vec++;
      if (readdata !== e) begin n_err++; $display("FAIL ram_load[%0d] got %h want %h", i, readdata, e); end
    end
  endtask

  task automatic test_display();
    store(32'hFF00, 32'h0000_A5F0);
    exp_q.push_back({4'h0, 7'b0001000, 7'b0010010, 7'b0001110, 7'b1000000});
    e = exp_q.pop_front(); n_vec++;
    if (digits() !== e) begin n_err++; $display("FAIL disp_a5f0_gled got %h want %h", digits(), e); end
    addr = 32'hFF00;
    exp_q.push_back(32'h0000_A5F0);
    #1;
    e = exp_q.pop_front(); n_vec++;
    if (readdata !== e) begin n_err++; $display("FAIL disp_read got %h want %h", readdata, e); end
    for (int h = 0; h < 16; h++) begin
      store(32'hFF00, 32'hFFFF_0000 | (32'(h) * 32'h1111));
      exp_q.push_back({4'h0, {4{seg_tab[h]}}});
      e = exp_q.pop_front(); n_vec++;
      if (digits() !== e) begin n_err++; $display("FAIL disp_digit[%0d] got %h want %h", h, digits(), e); end
    end
    addr = 32'hFF00;
    exp_q.push_back(32'h0000_FFFF);
    #1;
    e = exp_q.pop_front(); n_vec++;
    if (readdata !== e) begin n_err++; $display("FAIL disp_zero_ext got %h want %h", readdata, e); end
  endtask

  task automatic test_switch();
    addr = 32'hFF04;
    SW = 5'h15;
    for (int k = 1; k <= 6; k++) begin
      exp_q.push_back((k < 6) ? 32'h0 : 32'h15);
      tick(1);
      e = exp_q.pop_front(); n_vec++;
      if (readdata !== e) begin n_err++; $display("FAIL sw_settle[%0d] got %h want %h", k, readdata, e); end
    end
    SW = 5'h01;
    for (int k = 1; k <= 13; k++) begin
      if (k == 4) SW = 5'h15;
      exp_q.push_back(32'h15);
      tick(1);
      e = exp_q.pop_front(); n_vec++;
      if (readdata !== e) begin n_err++; $display("FAIL sw_glitch[%0d] got %h want %h", k, readdata, e); end
    end
    store(32'hFF04, 32'h0000_0003);
    addr = 32'hFF04;
    exp_q.push_back(32'h15);
    #1;
    e = exp_q.pop_front(); n_vec++;
    if (readdata !== e) begin n_err++; $display("FAIL sw_readonly got %h want %h", readdata, e); end
  endtask

  task automatic test_timer_compare();
    store(32'hFF0C, 32'd10);
    store(32'hFF08, 32'd5);
    store(32'hFF10, 32'd1);
    addr = 32'hFF10;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) tick(1);
      exp_q.push_back((k == 6) ? 32'h1 : 32'h0);
      #1;
      e = exp_q.pop_front(); n_vec++;
      if (readdata !== e) begin n_err++; $display("FAIL match_rise[%0d] got %h want %h", k, readdata, e); end
    end
    store(32'hFF10, 32'd0);
    addr = 32'hFF10; exp_q.push_back(32'h1); #1;
    e = exp_q.pop_front(); n_vec++;
    if (readdata !== e) begin n_err++; $display("FAIL stat_write0 got %h want %h", readdata, e); end
    store(32'hFF10, 32'd1);
    addr = 32'hFF10; exp_q.push_back(32'h0); #1;
    e = exp_q.pop_front(); n_vec++;
    if (readdata !== e) begin n_err++; $display("FAIL stat_clear got %h want %h", readdata, e); end
    store(32'hFF08, 32'd10);
    store(32'hFF10, 32'd1);
    addr = 32'hFF10; exp_q.push_back(32'h1); #1;
    e = exp_q.pop_front(); n_vec++;
    if (readdata !== e) begin n_err++; $display("FAIL set_beats_clear got %h want %h", readdata, e); end
    addr = 32'hFF0C; exp_q.push_back(32'd10); #1;
    e = exp_q.pop_front(); n_vec++;
    if (readdata !== e) begin n_err++; $display("FAIL cmp_read got %h want %h", readdata, e); end
  endtask

  task automatic test_boundary();
    logic [31:0] al [10];
    logic [31:0] ex [10];
    store(32'hFF10, 32'd1);
    store(32'hFF08, 32'hFFFF_FFFF);
    addr = 32'hFF08; exp_q.push_back(32'hFFFF_FFFF); #1;
    e = exp_q.pop_front(); n_vec++;
    if (readdata !== e) begin n_err++; $display("FAIL timer_max got %h want %h", readdata, e); end
    exp_q.push_back(32'h0);
    tick(1);
    e = exp_q.pop_front(); n_vec++;
    if (readdata !== e) begin n_err++; $display("FAIL timer_wrap got %h want %h", readdata, e); end
    store(32'h0000_0000, 32'h1234_5678);
    store(32'h0000_00FC, 32'h0BAD_F00D);
    store(32'h0001_0000, 32'hCAFE_F00D);
    store(32'h0000_FF14, 32'hFFFF_FFFF);
    store(32'h0001_FF00, 32'h0000_0000);
    store(32'h0000_0100, 32'h5555_5555);
    al = '{32'h0, 32'hFC, 32'h0001_0000, 32'hFF14, 32'h0001_FF00,
           32'h100, 32'hFF00, 32'hFF0C, 32'hFF10, 32'hFF04};
    ex = '{32'h1234_5678, 32'h0BAD_F00D, 32'h0, 32'h0, 32'h0,
           32'h0, 32'h0000_FFFF, 32'd10, 32'h0, 32'h15};
    for (int i = 0; i < 10; i++) exp_q.push_back(ex[i]);
    for (int i = 0; i < 10; i++) begin
      addr = al[i]; #1;
      e = exp_q.pop_front(); n_vec++;
      if (readdata !== e) begin n_err++; $display("FAIL unmapped[%0d] got %h want %h", i, readdata, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] al [7];
    logic [31:0] ex [7];
    SW = 5'h0A;
    tick(3);
    reset = 1'b0;
    store(32'hFF00, 32'h0000_BEEF);
    store(32'h0000_0020, 32'h55AA_55AA);
    exp_q.push_back({4'h0, {4{7'b1000000}}});
    e = exp_q.pop_front(); n_vec++;
    if (digits() !== e) begin n_err++; $display("FAIL mid_reset_gled got %h want %h", digits(), e); end
    al = '{32'hFF00, 32'hFF04, 32'hFF08, 32'hFF0C, 32'hFF10, 32'h0C, 32'h20};
    ex = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'hDEAD_BEEF, 32'h55AA_55AA};
    for (int i = 0; i < 7; i++) exp_q.push_back(ex[i]);
    for (int i = 0; i < 7; i++) begin
      addr = al[i]; #1;
      e = exp_q.pop_front(); n_vec++;
      if (readdata !== e) begin n_err++; $display("FAIL mid_reset[%0d] got %h want %h", i, readdata, e); end
    end
    reset = 1'b1;
    addr = 32'hFF08;
    exp_q.push_back(32'h1);
    tick(1);
    e = exp_q.pop_front(); n_vec++;
    if (readdata !== e) begin n_err++; $display("FAIL mid_reset_release got %h want %h", readdata, e); end
    addr = 32'hFF04; exp_q.push_back(32'h0); #1;
    e = exp_q.pop_front(); n_vec++;
    if (readdata !== e) begin n_err++; $display("FAIL mid_reset_sw got %h want %h", readdata, e); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    test_reset();
    test_ram();
    test_display();
    test_switch();
    test_timer_compare();
    test_boundary();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
